prescaler_multi: RTL and testbench



---
 rtl/prescaler_multi.sv | 70 +++++++
 tb/tb_prescaler_multi.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prescaler_multi.sv
// Multi-channel clock-enable prescaler: each channel emits a one-cycle strobe
// every R enabled cycles, with run-time ratio reload and a common phase-align sync.
module prescaler_multi #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 16,
    parameter int DEF_DIV = 50
) (
    input  logic                    clk50m,
    input  logic                    rst,
    input  logic [N_CH-1:0]         en_ch,
    input  logic [N_CH*CNT_W-1:0]   div_i,
    input  logic [N_CH-1:0]         div_ld,
    input  logic                    sync,
    output logic [N_CH-1:0]         tick_o,
    output logic [N_CH*CNT_W-1:0]   div_act_o
);

    localparam logic [CNT_W-1:0] DEF_R = CNT_W'(DEF_DIV);

    // A stored ratio of zero behaves as divide-by-one.
    function automatic logic [CNT_W-1:0] ratio_clamp(input logic [CNT_W-1:0] r);
        return (r == '0) ? CNT_W'(1) : r;
    endfunction

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic [CNT_W-1:0] div_new;
        logic [CNT_W-1:0] shadow_q;
        logic [CNT_W-1:0] act_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] sync_src;
        logic             tick_q;

        assign div_new  = div_i[ch*CNT_W +: CNT_W];
        assign sync_src = div_ld[ch] ? div_new : shadow_q;

        always_ff @(posedge clk50m or posedge rst) begin
            if (rst) begin
                shadow_q <= DEF_R;
                act_q    <= DEF_R;
                cnt_q    <= DEF_R - CNT_W'(1);
                tick_q   <= 1'b0;
            end else begin
                if (div_ld[ch]) begin
                    shadow_q <= div_new;
                end
                // Sync parks every channel at its reload value, enabled or not.
                if (sync) begin
                    act_q  <= ratio_clamp(sync_src);
                    cnt_q  <= ratio_clamp(sync_src) - CNT_W'(1);
                    tick_q <= 1'b0;
                end else if (en_ch[ch]) begin
                    if (cnt_q == '0) begin
                        act_q  <= ratio_clamp(shadow_q);
                        cnt_q  <= ratio_clamp(shadow_q) - CNT_W'(1);
                        tick_q <= 1'b1;
                    end else begin
                        cnt_q  <= cnt_q - CNT_W'(1);
                        tick_q <= 1'b0;
                    end
                end else begin
                    tick_q <= 1'b0;
                end
            end
        end

        assign tick_o[ch]                    = tick_q;
        assign div_act_o[ch*CNT_W +: CNT_W]  = act_q;
    end

endmodule

// File: tb/tb_prescaler_multi.sv
// Bench for prescaler_multi: per-cycle scoreboard plus hand-counted tick tables.
module tb_prescaler_multi;

    localparam int N_CH = 4;
    localparam int CNT_W = 16;

    logic                  clk50m = 1'b0;
    logic                  rst = 1'b1;
    logic [N_CH-1:0]       en_ch = '0;
    logic [N_CH*CNT_W-1:0] div_i = '0;
    logic [N_CH-1:0]       div_ld = '0;
    logic                  sync = 1'b0;
    logic [N_CH-1:0]       tick_o;
    logic [N_CH*CNT_W-1:0] div_act_o;

    prescaler_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .DEF_DIV(50)) dut (
        .clk50m    (clk50m),
        .rst       (rst),
        .en_ch     (en_ch),
        .div_i     (div_i),
        .div_ld    (div_ld),
        .sync      (sync),
        .tick_o    (tick_o),
        .div_act_o (div_act_o)
    );

    always #5 clk50m = ~clk50m;

    typedef struct {
        logic [3:0]  en;
        logic [63:0] dv;
        logic [3:0]  ld;
        logic        sy;
        int          ncyc;
        logic [31:0] exp_cnt;
        logic [63:0] exp_act;
    } vec_t;

    vec_t vt[25];

    int checks = 0;
    int errors = 0;

    logic [15:0] m_sh[4];
    logic [15:0] m_r[4];
    logic [15:0] m_cnt[4];
    logic [3:0]  m_tick;
    logic [67:0] exp_q[$];

    function automatic logic [63:0] pk16(input int a0, input int a1, input int a2, input int a3);
        return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    function automatic logic [31:0] pk8(input int a0, input int a1, input int a2, input int a3);
        return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic vec_t mk(input logic [3:0] en, input logic [63:0] dv, input logic [3:0] ld,
                                input logic sy, input int n, input logic [31:0] ec, input logic [63:0] ea);
        vec_t v;
        v.en = en; v.dv = dv; v.ld = ld; v.sy = sy; v.ncyc = n; v.exp_cnt = ec; v.exp_act = ea;
        return v;
    endfunction

    function automatic logic [15:0] at_least_one(input logic [15:0] r);
        return (r == 16'd0) ? 16'd1 : r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_sh[c] = 16'd50; m_r[c] = 16'd50; m_cnt[c] = 16'd49;
        end
        m_tick = '0;
    endtask

    // Reference behaviour for one rising edge, expressed channel by channel.
    task automatic model_step(input logic [3:0] en, input logic [63:0] dv, input logic [3:0] ld, input logic sy);
        logic [15:0] nv;
        logic [63:0] act;
        for (int c = 0; c < N_CH; c++) begin
            nv = dv[c*16 +: 16];
            if (sy) begin
                m_r[c] = at_least_one(ld[c] ? nv : m_sh[c]);
                m_cnt[c] = m_r[c] - 16'd1;
                m_tick[c] = 1'b0;
            end else if (en[c]) begin
                if (m_cnt[c] == 16'd0) begin
                    m_tick[c] = 1'b1;
                    m_r[c] = at_least_one(m_sh[c]);
                    m_cnt[c] = m_r[c] - 16'd1;
                end else begin
                    m_cnt[c] = m_cnt[c] - 16'd1;
                    m_tick[c] = 1'b0;
                end
            end else begin
                m_tick[c] = 1'b0;
            end
            if (ld[c]) m_sh[c] = nv;
        end
        act = {m_r[3], m_r[2], m_r[1], m_r[0]};
        exp_q.push_back({m_tick, act});
    endtask

    task automatic step(input logic [3:0] en, input logic [63:0] dv, input logic [3:0] ld, input logic sy);
        logic [67:0] e;
        @(negedge clk50m);
        en_ch = en; div_i = dv; div_ld = ld; sync = sy;
        model_step(en, dv, ld, sy);
        @(posedge clk50m);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: no expected entry queued");
        end else begin
            e = exp_q.pop_front();
            if (tick_o !== e[67:64]) begin
                errors++;
                $display("FAIL tick_cycle t=%0t: got %b expected %b", $time, tick_o, e[67:64]);
            end
            checks++;
            if (div_act_o !== e[63:0]) begin
                errors++;
                $display("FAIL act_cycle t=%0t: got %h expected %h", $time, div_act_o, e[63:0]);
            end
        end
    endtask

    task automatic run_row(input int i);
        int cnt[4];
        for (int c = 0; c < N_CH; c++) cnt[c] = 0;
        for (int k = 0; k < vt[i].ncyc; k++) begin
            step(vt[i].en, vt[i].dv, vt[i].ld, vt[i].sy);
            for (int c = 0; c < N_CH; c++) if (tick_o[c] === 1'b1) cnt[c]++;
        end
        for (int c = 0; c < N_CH; c++) begin
            checks++;
            if (cnt[c] != int'(vt[i].exp_cnt[c*8 +: 8])) begin
                errors++;
                $display("FAIL row%0d_ticks_ch%0d: got %0d expected %0d", i, c, cnt[c], vt[i].exp_cnt[c*8 +: 8]);
            end
        end
        checks++;
        if (div_act_o !== vt[i].exp_act) begin
            errors++;
            $display("FAIL row%0d_div_act: got %h expected %h", i, div_act_o, vt[i].exp_act);
        end
    endtask

    task automatic check_reset_state(input string tag);
        checks++;
        if (tick_o !== 4'b0000) begin
            errors++;
            $display("FAIL %s_tick: got %b expected 0000", tag, tick_o);
        end
        checks++;
        if (div_act_o !== pk16(50, 50, 50, 50)) begin
            errors++;
            $display("FAIL %s_div_act: got %h expected %h", tag, div_act_o, pk16(50, 50, 50, 50));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d50, dA, dB, dC, dD, dE, dF;
        d50 = pk16(50, 50, 50, 50);
        dA  = pk16(3, 1, 0, 7);
        dB  = pk16(10, 1, 0, 7);
        dC  = pk16(4, 1, 0, 7);
        dD  = pk16(4, 8, 0, 7);
        dE  = pk16(9, 9, 5, 9);
        dF  = pk16(0, 0, 0, 0);

        // defaults after reset
        vt[0]  = mk(4'hF, d50, 4'h0, 1'b0, 49, pk8(0, 0, 0, 0),    d50);
        vt[1]  = mk(4'hF, d50, 4'h0, 1'b0, 1,  pk8(1, 1, 1, 1),    d50);
        vt[2]  = mk(4'hF, d50, 4'h0, 1'b0, 50, pk8(1, 1, 1, 1),    d50);
        // mixed ratios, 0 acting as 1, coincidence every 21
        vt[3]  = mk(4'hF, dA,  4'hF, 1'b1, 1,  pk8(0, 0, 0, 0),    pk16(3, 1, 1, 7));
        vt[4]  = mk(4'hF, dA,  4'h0, 1'b0, 21, pk8(7, 21, 21, 3),  pk16(3, 1, 1, 7));
        vt[5]  = mk(4'hF, dA,  4'h0, 1'b0, 21, pk8(7, 21, 21, 3),  pk16(3, 1, 1, 7));
        // mid-period ratio change on ch0
        vt[6]  = mk(4'hF, dB,  4'h1, 1'b1, 1,  pk8(0, 0, 0, 0),    pk16(10, 1, 1, 7));
        vt[7]  = mk(4'hF, dB,  4'h0, 1'b0, 3,  pk8(0, 3, 3, 0),    pk16(10, 1, 1, 7));
        vt[8]  = mk(4'hF, dC,  4'h1, 1'b0, 1,  pk8(0, 1, 1, 0),    pk16(10, 1, 1, 7));
        vt[9]  = mk(4'hF, dC,  4'h0, 1'b0, 5,  pk8(0, 5, 5, 1),    pk16(10, 1, 1, 7));
        vt[10] = mk(4'hF, dC,  4'h0, 1'b0, 1,  pk8(1, 1, 1, 0),    pk16(4, 1, 1, 7));
        vt[11] = mk(4'hF, dC,  4'h0, 1'b0, 4,  pk8(1, 4, 4, 1),    pk16(4, 1, 1, 7));
        // enable freeze on ch1
        vt[12] = mk(4'hF, dD,  4'h2, 1'b1, 1,  pk8(0, 0, 0, 0),    pk16(4, 8, 1, 7));
        vt[13] = mk(4'hF, dD,  4'h0, 1'b0, 4,  pk8(1, 0, 4, 0),    pk16(4, 8, 1, 7));
        vt[14] = mk(4'hD, dD,  4'h0, 1'b0, 5,  pk8(1, 0, 5, 1),    pk16(4, 8, 1, 7));
        vt[15] = mk(4'hF, dD,  4'h0, 1'b0, 3,  pk8(1, 0, 3, 0),    pk16(4, 8, 1, 7));
        vt[16] = mk(4'hF, dD,  4'h0, 1'b0, 1,  pk8(0, 1, 1, 0),    pk16(4, 8, 1, 7));
        vt[17] = mk(4'hF, dD,  4'h0, 1'b0, 8,  pk8(2, 1, 8, 2),    pk16(4, 8, 1, 7));
        // after asynchronous reset
        vt[18] = mk(4'hF, dF,  4'h0, 1'b0, 49, pk8(0, 0, 0, 0),    d50);
        vt[19] = mk(4'hF, dF,  4'h0, 1'b0, 1,  pk8(1, 1, 1, 1),    d50);
        // sync with same-edge load on ch2, sync held three cycles
        vt[20] = mk(4'hF, dE,  4'h4, 1'b1, 1,  pk8(0, 0, 0, 0),    pk16(50, 50, 5, 50));
        vt[21] = mk(4'hF, dE,  4'h0, 1'b1, 2,  pk8(0, 0, 0, 0),    pk16(50, 50, 5, 50));
        vt[22] = mk(4'hF, dE,  4'h0, 1'b0, 4,  pk8(0, 0, 0, 0),    pk16(50, 50, 5, 50));
        vt[23] = mk(4'hF, dE,  4'h0, 1'b0, 1,  pk8(0, 0, 1, 0),    pk16(50, 50, 5, 50));
        vt[24] = mk(4'hF, dE,  4'h0, 1'b0, 10, pk8(0, 0, 2, 0),    pk16(50, 50, 5, 50));

        model_reset();
        repeat (2) @(posedge clk50m);
        #1;
        check_reset_state("reset_initial");
        #2;
        rst = 1'b0;

        for (int i = 0; i <= 17; i++) run_row(i);

        // Asynchronous reset between edges while ch2 ticks every cycle.
        @(posedge clk50m);
        #3;
        rst = 1'b1;
        #1;
        check_reset_state("reset_async");
        @(negedge clk50m);
        en_ch = 4'hF; div_ld = 4'h0; sync = 1'b0;
        @(posedge clk50m);
        #1;
        check_reset_state("reset_held_edge");
        #2;
        rst = 1'b0;
        model_reset();
        exp_q.delete();

        for (int i = 18; i <= 24; i++) run_row(i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
